// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit sitting beside the EX-stage ALU.
// One result bit per cycle: radix-2 shift-add for MUL*, restoring
// shift-subtract for DIV*/REM*, both on unsigned magnitudes with the sign
// and the RISC-V special cases applied on the final (finish) cycle.
// A request takes DATA_WIDTH iteration cycles plus one finish cycle in CALC.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [2:0]      op;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            neg;
  logic            div_zero;
  logic            div_ovf;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   count;

  logic            accept;
  logic            last;
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [W-1:0]    mag_a_in;
  logic [W-1:0]    mag_b_in;
  logic            neg_in;
  logic            ovf_in;
  logic            zero_in;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    div_sub;
  logic [2*W-1:0]  div_next;

  // Two's-complement magnitude of a possibly-signed operand.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic s);
    return s ? -x : x;
  endfunction

  // Applies the result sign, picks the half / quotient / remainder and
  // substitutes the divide-by-zero and signed-overflow results.
  function automatic logic [W-1:0] finish_result(
    input logic [2:0]     f,
    input logic [2*W-1:0] a,
    input logic           n,
    input logic           dz,
    input logic           ov
  );
    logic [2*W-1:0] p;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic [W-1:0]   res;
    p = n ? -a : a;
    q = n ? -a[W-1:0] : a[W-1:0];
    r = n ? -a[2*W-1:W] : a[2*W-1:W];
    case (f)
      3'b000:                 res = p[W-1:0];
      3'b001, 3'b010, 3'b011: res = p[2*W-1:W];
      3'b100, 3'b101:         res = dz ? {W{1'b1}} : (ov ? MIN_VAL : q);
      default:                res = ov ? {W{1'b0}} : r;
    endcase
    return res;
  endfunction

  assign accept   = start && (state == IDLE || state == DONE);
  assign last     = (count == CW'(W));

  // Operand decode at accept: which operands are signed, their magnitudes,
  // the final result sign (remainder follows the dividend) and special cases.
  assign a_signed = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
  assign b_signed = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
  assign sign_a   = a_signed && SrcA[W-1];
  assign sign_b   = b_signed && SrcB[W-1];
  assign mag_a_in = magnitude(SrcA, sign_a);
  assign mag_b_in = magnitude(SrcB, sign_b);
  assign neg_in   = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
  assign zero_in  = (SrcB == {W{1'b0}});
  assign ovf_in   = (funct3 == 3'b100 || funct3 == 3'b110) &&
                    (SrcA == MIN_VAL) && (SrcB == {W{1'b1}});

  // One iteration step for each algorithm; acc holds {hi, lo}. For divide
  // lo shifts the dividend out while quotient bits shift in, hi is the
  // partial remainder, which is always below the divisor after a step so the
  // W-bit subtraction is exact whenever it is taken.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_sub   = div_shift[W-1:0] - mag_b;
    div_next  = {(div_ge ? div_sub : div_shift[W-1:0]), acc[W-2:0], div_ge};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and the busy/done status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-cycle iteration and the result write on the finish cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op       <= 3'b000;
      mag_a    <= {W{1'b0}};
      mag_b    <= {W{1'b0}};
      neg      <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      acc      <= {(2*W){1'b0}};
      count    <= {CW{1'b0}};
      Result   <= {W{1'b0}};
    end else if (accept) begin
      op       <= funct3;
      mag_a    <= mag_a_in;
      mag_b    <= mag_b_in;
      neg      <= neg_in;
      div_zero <= zero_in;
      div_ovf  <= ovf_in;
      acc      <= {{W{1'b0}}, (funct3[2] ? mag_a_in : mag_b_in)};
      count    <= {CW{1'b0}};
    end else if (state == CALC) begin
      if (last) begin
        Result <= finish_result(op, acc, neg, div_zero, div_ovf);
      end else begin
        acc   <= op[2] ? div_next : mul_next;
        count <= count + CW'(1);
      end
    end
  end

endmodule
